// File: rtl/rcon_sequencer_if.sv
// Handshake/data bundle between an AES key-schedule controller and the
// round-constant sequencer.
interface rcon_sequencer_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic [1:0]        key_len;
    logic              dir;
    logic              next;
    logic [WORD_W-1:0] rcon_column;
    logic [3:0]        round_num;
    logic              valid;
    logic              last;
    logic              err;

    modport master (
        output start, key_len, dir, next,
        input  rcon_column, round_num, valid, last, err
    );

    modport slave (
        input  start, key_len, dir, next,
        output rcon_column, round_num, valid, last, err
    );
endinterface

// File: rtl/rcon_sequencer.sv
// AES round-constant sequencer: steps Rcon forward (xtime) or backward
// (inverse xtime) through 1..N rounds for AES-128/192/256.
module rcon_sequencer #(
    parameter int        WORD_W = 32,
    parameter logic [7:0] POLY  = 8'h1b
) (
    input  logic             clk,
    input  logic             rst_n,
    rcon_sequencer_if.slave  bus
);
    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t     r_state;
    logic [7:0] r_byte;
    logic [3:0] r_round;
    logic [3:0] r_n;
    logic       r_dir;
    logic       r_valid;
    logic       r_err;

    logic [3:0]        w_n;
    logic              w_legal;
    logic              w_last;
    logic [WORD_W-1:0] w_col;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? (((b ^ POLY) >> 1) | 8'h80) : (b >> 1);
    endfunction

    // Nth constant derived from POLY so the reverse start tracks the polynomial.
    function automatic logic [7:0] rcon_at(input logic [3:0] n);
        logic [7:0] b;
        b = 8'h01;
        for (int unsigned i = 1; i < 10; i++) begin
            if (i < 32'(n)) b = xtime(b);
        end
        return b;
    endfunction

    always_comb begin
        w_n = 4'd0;
        case (bus.key_len)
            2'd0:    w_n = 4'd10;
            2'd1:    w_n = 4'd8;
            2'd2:    w_n = 4'd7;
            default: w_n = 4'd0;
        endcase
    end

    assign w_legal = (bus.key_len != 2'd3);
    assign w_last  = (r_state == ACTIVE) &&
                     (r_dir ? (r_round == 4'd1) : (r_round == r_n));

    always_comb begin
        w_col = '0;
        w_col[WORD_W-1 -: 8] = r_byte;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_byte  <= '0;
            r_round <= '0;
            r_n     <= '0;
            r_dir   <= 1'b0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            // start outranks next; an illegal start also suppresses next.
            if (bus.start) begin
                if (w_legal) begin
                    r_state <= ACTIVE;
                    r_n     <= w_n;
                    r_dir   <= bus.dir;
                    r_valid <= 1'b1;
                    if (bus.dir) begin
                        r_round <= w_n;
                        r_byte  <= rcon_at(w_n);
                    end else begin
                        r_round <= 4'd1;
                        r_byte  <= 8'h01;
                    end
                end else begin
                    r_err <= 1'b1;
                end
            end else if (bus.next && (r_state == ACTIVE)) begin
                if (w_last) begin
                    r_state <= IDLE;
                    r_byte  <= '0;
                    r_round <= '0;
                    r_valid <= 1'b0;
                end else if (r_dir) begin
                    r_byte  <= inv_xtime(r_byte);
                    r_round <= r_round - 4'd1;
                end else begin
                    r_byte  <= xtime(r_byte);
                    r_round <= r_round + 4'd1;
                end
            end
        end
    end

    assign bus.rcon_column = w_col;
    assign bus.round_num   = r_round;
    assign bus.valid       = r_valid;
    assign bus.last        = w_last;
    assign bus.err         = r_err;
endmodule

// File: tb/tb_rcon_sequencer.sv
// Directed self-checking bench for rcon_sequencer (32-bit and 8-bit builds).
module tb_rcon_sequencer;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    rcon_sequencer_if #(.WORD_W(32)) bus ();
    rcon_sequencer_if #(.WORD_W(8))  bus8 ();

    rcon_sequencer #(.WORD_W(32), .POLY(8'h1b)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    rcon_sequencer #(.WORD_W(8), .POLY(8'h1b)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    // FIPS-197 Rcon[1..10]
    logic [7:0] rc [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                              8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    logic [38:0] w_obs;
    assign w_obs = {bus.valid, bus.last, bus.err, bus.round_num, bus.rcon_column};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [38:0] ex(input logic v, input logic l, input logic e,
                                       input int r, input logic [7:0] b);
        return {v, l, e, 4'(r), b, 24'h000000};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.key_len = 2'd0; bus.dir = 1'b0; bus.next = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus8.start = 1'b0; bus8.key_len = 2'd0; bus8.dir = 1'b0; bus8.next = 1'b0;
        #12;
        checks++;
        if (w_obs !== 39'h0) begin
            errors++;
            $display("FAIL reset obs=%h exp=%h", w_obs, 39'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic run_fwd(input logic [1:0] kl, input int n, input string name);
        bus.start = 1'b1; bus.key_len = kl; bus.dir = 1'b0; bus.next = 1'b0;
        step();
        bus.start = 1'b0;
        checks++;
        if (w_obs !== ex(1, 0, 0, 1, rc[1])) begin
            errors++;
            $display("FAIL %s_first obs=%h exp=%h", name, w_obs, ex(1, 0, 0, 1, rc[1]));
        end
        bus.next = 1'b1;
        for (int r = 2; r <= n; r++) begin
            step();
            checks++;
            if (w_obs !== ex(1, r == n, 0, r, rc[r])) begin
                errors++;
                $display("FAIL %s_round%0d obs=%h exp=%h", name, r, w_obs, ex(1, r == n, 0, r, rc[r]));
            end
        end
        step();
        bus.next = 1'b0;
        checks++;
        if (w_obs !== 39'h0) begin
            errors++;
            $display("FAIL %s_done obs=%h exp=%h", name, w_obs, 39'h0);
        end
    endtask

    task automatic run_rev(input logic [1:0] kl, input int n, input string name);
        bus.start = 1'b1; bus.key_len = kl; bus.dir = 1'b1; bus.next = 1'b0;
        step();
        bus.start = 1'b0;
        checks++;
        if (w_obs !== ex(1, 0, 0, n, rc[n])) begin
            errors++;
            $display("FAIL %s_first obs=%h exp=%h", name, w_obs, ex(1, 0, 0, n, rc[n]));
        end
        bus.next = 1'b1;
        for (int r = n - 1; r >= 1; r--) begin
            step();
            checks++;
            if (w_obs !== ex(1, r == 1, 0, r, rc[r])) begin
                errors++;
                $display("FAIL %s_round%0d obs=%h exp=%h", name, r, w_obs, ex(1, r == 1, 0, r, rc[r]));
            end
        end
        step();
        bus.next = 1'b0;
        checks++;
        if (w_obs !== 39'h0) begin
            errors++;
            $display("FAIL %s_done obs=%h exp=%h", name, w_obs, 39'h0);
        end
    endtask

    task automatic test_fwd128(); run_fwd(2'd0, 10, "fwd128"); endtask
    task automatic test_rev128(); run_rev(2'd0, 10, "rev128"); endtask
    task automatic test_fwd192(); run_fwd(2'd1, 8, "fwd192"); endtask
    task automatic test_rev256(); run_rev(2'd2, 7, "rev256"); endtask

    task automatic test_hold_restart();
        bus.start = 1'b1; bus.key_len = 2'd0; bus.dir = 1'b0; bus.next = 1'b0;
        step();
        bus.start = 1'b0; bus.next = 1'b1;
        step(); step(); step();
        bus.next = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (w_obs !== ex(1, 0, 0, 4, 8'h08)) begin
                errors++;
                $display("FAIL hold_cycle%0d obs=%h exp=%h", i, w_obs, ex(1, 0, 0, 4, 8'h08));
            end
        end
        bus.next = 1'b1;
        step(); step();
        checks++;
        if (w_obs !== ex(1, 0, 0, 6, 8'h20)) begin
            errors++;
            $display("FAIL hold_round6 obs=%h exp=%h", w_obs, ex(1, 0, 0, 6, 8'h20));
        end
        bus.start = 1'b1;
        step();
        bus.start = 1'b0; bus.next = 1'b0;
        checks++;
        if (w_obs !== ex(1, 0, 0, 1, 8'h01)) begin
            errors++;
            $display("FAIL restart obs=%h exp=%h", w_obs, ex(1, 0, 0, 1, 8'h01));
        end
        bus.next = 1'b1;
        step();
        checks++;
        if (w_obs !== ex(1, 0, 0, 2, 8'h02)) begin
            errors++;
            $display("FAIL restart_next obs=%h exp=%h", w_obs, ex(1, 0, 0, 2, 8'h02));
        end
        bus.next = 1'b0;
    endtask

    task automatic test_illegal();
        // sequencer is ACTIVE at round 2 from the previous test
        bus.start = 1'b1; bus.key_len = 2'd3; bus.dir = 1'b1; bus.next = 1'b1;
        step();
        idle_inputs();
        checks++;
        if (w_obs !== ex(1, 0, 1, 2, 8'h02)) begin
            errors++;
            $display("FAIL illegal_active obs=%h exp=%h", w_obs, ex(1, 0, 1, 2, 8'h02));
        end
        step();
        checks++;
        if (w_obs !== ex(1, 0, 0, 2, 8'h02)) begin
            errors++;
            $display("FAIL illegal_active_after obs=%h exp=%h", w_obs, ex(1, 0, 0, 2, 8'h02));
        end
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        bus.start = 1'b1; bus.key_len = 2'd3;
        step();
        idle_inputs();
        checks++;
        if (w_obs !== ex(0, 0, 1, 0, 8'h00)) begin
            errors++;
            $display("FAIL illegal_idle obs=%h exp=%h", w_obs, ex(0, 0, 1, 0, 8'h00));
        end
        step();
        checks++;
        if (w_obs !== 39'h0) begin
            errors++;
            $display("FAIL illegal_idle_after obs=%h exp=%h", w_obs, 39'h0);
        end
    endtask

    task automatic test_async_reset();
        bus.start = 1'b1; bus.key_len = 2'd0; bus.dir = 1'b0;
        step();
        bus.start = 1'b0; bus.next = 1'b1;
        step(); step(); step(); step();
        bus.next = 1'b0;
        checks++;
        if (w_obs !== ex(1, 0, 0, 5, 8'h10)) begin
            errors++;
            $display("FAIL areset_pre obs=%h exp=%h", w_obs, ex(1, 0, 0, 5, 8'h10));
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (w_obs !== 39'h0) begin
            errors++;
            $display("FAIL areset_immediate obs=%h exp=%h", w_obs, 39'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = 1'b1; bus.key_len = 2'd0; bus.dir = 1'b0;
        step();
        bus.start = 1'b0;
        checks++;
        if (w_obs !== ex(1, 0, 0, 1, 8'h01)) begin
            errors++;
            $display("FAIL areset_restart obs=%h exp=%h", w_obs, ex(1, 0, 0, 1, 8'h01));
        end
    endtask

    task automatic test_word8();
        bus8.start = 1'b1; bus8.key_len = 2'd0; bus8.dir = 1'b0; bus8.next = 1'b0;
        step();
        bus8.start = 1'b0; bus8.next = 1'b1;
        checks++;
        if (bus8.rcon_column !== 8'h01 || bus8.round_num !== 4'd1) begin
            errors++;
            $display("FAIL word8_first col=%h round=%0d exp col=01 round=1", bus8.rcon_column, bus8.round_num);
        end
        step();
        checks++;
        if (bus8.rcon_column !== 8'h02) begin
            errors++;
            $display("FAIL word8_next col=%h exp=02", bus8.rcon_column);
        end
        bus8.next = 1'b0; bus8.start = 1'b1; bus8.key_len = 2'd2; bus8.dir = 1'b1;
        step();
        bus8.start = 1'b0;
        checks++;
        if (bus8.rcon_column !== 8'h40 || bus8.round_num !== 4'd7) begin
            errors++;
            $display("FAIL word8_rev col=%h round=%0d exp col=40 round=7", bus8.rcon_column, bus8.round_num);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fwd128();
        test_rev128();
        test_fwd192();
        test_rev256();
        test_hold_restart();
        test_illegal();
        test_async_reset();
        test_word8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout waiting for test sequence");
        $fatal(1, "timeout");
    end
endmodule
